// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM states,
// opcode and funct field values, ALU control encodings and the ALU
// operation class handed from the main FSM to the ALU decoder.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    RTYPEEX,
    RTYPEWB,
    BEQEX,
    ADDIEX,
    ADDIWB,
    JEX
  } statetype;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/aludec.sv
// ALU decoder: turns the FSM's ALU operation class, plus the R-type funct
// field when the class asks for it, into the 3-bit ALU control code.
module aludec
  import mips_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // Unknown funct codes fall back to ADD so the ALU never sees an undefined op.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: a Moore FSM that sequences fetch, decode
// and the per-instruction execute/writeback steps. The only storage is the
// state register; op and funct are read straight from the instruction
// register every cycle.
module mc_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alucontrol,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite
);

  statetype state;
  statetype nextstate;
  aluop_t   aluop;
  logic     pcwrite;
  logic     branch;
  logic     fsm_irwrite;
  logic     fsm_memwrite;
  logic     fsm_regwrite;

  // State register; reset drops straight back to FETCH even mid-instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= nextstate;
  end

  // Next-state logic: DECODE dispatches on op, MEMADR splits lw from sw.
  always_comb begin
    nextstate = FETCH;
    case (state)
      FETCH: nextstate = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nextstate = MEMADR;
          OP_RTYPE:     nextstate = RTYPEEX;
          OP_BEQ:       nextstate = BEQEX;
          OP_ADDI:      nextstate = ADDIEX;
          OP_J:         nextstate = JEX;
          default:      nextstate = FETCH;
        endcase
      end
      MEMADR:  nextstate = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   nextstate = MEMWB;
      RTYPEEX: nextstate = RTYPEWB;
      ADDIEX:  nextstate = ADDIWB;
      default: nextstate = FETCH;
    endcase
  end

  // Moore outputs: everything idles low unless the current state drives it.
  always_comb begin
    fsm_irwrite  = 1'b0;
    fsm_memwrite = 1'b0;
    fsm_regwrite = 1'b0;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    iord         = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = ALUOP_ADD;
    case (state)
      FETCH: begin
        fsm_irwrite = 1'b1;
        alusrcb     = 2'b01;
        pcwrite     = 1'b1;
      end
      DECODE: begin
        alusrcb = 2'b11;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        iord = 1'b1;
      end
      MEMWB: begin
        memtoreg     = 1'b1;
        fsm_regwrite = 1'b1;
      end
      MEMWR: begin
        iord         = 1'b1;
        fsm_memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        regdst       = 1'b1;
        fsm_regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: begin
        fsm_regwrite = 1'b1;
      end
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // While reset is held, no architectural state may be written.
  assign irwrite  = fsm_irwrite  & ~reset;
  assign memwrite = fsm_memwrite & ~reset;
  assign regwrite = fsm_regwrite & ~reset;
  assign pcen     = (pcwrite | (branch & zero)) & ~reset;

  aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: runs directed and random
// instruction streams and compares every cycle's control outputs with a
// per-instruction step table derived from the instruction semantics.
module tb_mc_controller;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RTY  = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
  } ctrl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] alucontrol;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite;
  ctrl_t      obs;

  int compareCount  = 0;
  int mismatchCount = 0;

  always #5 clk = ~clk;

  assign obs = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                alusrca, alusrcb, pcsrc, alucontrol};

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .alucontrol (alucontrol),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [14:0] observed,
                             input logic [14:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %b required %b", tag, observed, expected);
    end
  endtask

  function automatic logic [2:0] functToAlu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic int instrLatency(input logic [5:0] o);
    case (o)
      LW:        return 5;
      SW, RTY:   return 4;
      ADDI:      return 4;
      BEQ, JMP:  return 3;
      default:   return 2;
    endcase
  endfunction

  function automatic bit isSupported(input logic [5:0] o);
    return (o == LW) || (o == SW) || (o == RTY) || (o == BEQ) ||
           (o == ADDI) || (o == JMP);
  endfunction

  // Expected controls for a given step (0 = first cycle) of an instruction.
  function automatic void expectStep(input logic [5:0] o, input logic [5:0] f,
                                     input logic z, input int step,
                                     output ctrl_t e, output bit aluCare);
    e = '0;
    aluCare = 1'b0;
    if (step == 0) begin
      e.irwrite = 1'b1; e.alusrcb = 2'b01; e.pcen = 1'b1;
      e.alucontrol = 3'b010; aluCare = 1'b1;
    end else if (step == 1) begin
      e.alusrcb = 2'b11; e.alucontrol = 3'b010; aluCare = 1'b1;
    end else begin
      case (o)
        LW, SW: begin
          if (step == 2) begin
            e.alusrca = 1'b1; e.alusrcb = 2'b10;
            e.alucontrol = 3'b010; aluCare = 1'b1;
          end else if (step == 3) begin
            e.iord = 1'b1; e.memwrite = (o == SW);
          end else begin
            e.memtoreg = 1'b1; e.regwrite = 1'b1;
          end
        end
        RTY: begin
          if (step == 2) begin
            e.alusrca = 1'b1; e.alucontrol = functToAlu(f); aluCare = 1'b1;
          end else begin
            e.regdst = 1'b1; e.regwrite = 1'b1;
          end
        end
        BEQ: begin
          e.alusrca = 1'b1; e.alucontrol = 3'b110; aluCare = 1'b1;
          e.pcsrc = 2'b01; e.pcen = z;
        end
        ADDI: begin
          if (step == 2) begin
            e.alusrca = 1'b1; e.alusrcb = 2'b10;
            e.alucontrol = 3'b010; aluCare = 1'b1;
          end else begin
            e.regwrite = 1'b1;
          end
        end
        JMP: begin
          e.pcsrc = 2'b10; e.pcen = 1'b1;
        end
        default: ;
      endcase
    end
  endfunction

  // Reset view: FETCH selects, with every write enable held low.
  task automatic checkResetState(input string tag);
    ctrl_t e;
    e = '0;
    e.alusrcb = 2'b01;
    e.alucontrol = 3'b010;
    checkOutput(tag, obs, e);
  endtask

  task automatic holdAndReleaseReset();
    repeat (2) begin
      @(negedge clk);
      #1;
      checkResetState("reset_hold");
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Runs one instruction cycle by cycle; abortAt >= 0 asserts reset mid-way.
  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f,
                               input int zeroMode, input int abortAt);
    ctrl_t e;
    bit care;
    logic [14:0] mask;
    for (int step = 0; step < instrLatency(o); step++) begin
      @(negedge clk);
      op = o;
      funct = f;
      zero = (zeroMode == 2) ? 1'($urandom_range(0, 1)) : (zeroMode == 1);
      #1;
      expectStep(o, f, zero, step, e, care);
      mask = care ? 15'h7fff : 15'h7ff8;
      checkOutput($sformatf("op%b_f%b_step%0d", o, f, step), obs & mask, e & mask);
      if (step == abortAt) begin
        #2;
        reset = 1'b1;
        #1;
        checkResetState("reset_async");
        return;
      end
    end
  endtask

  initial begin
    logic [5:0] ro;
    logic [5:0] rf;
    int sel;
    int abortAt;
    logic [5:0] functs [5];
    functs[0] = 6'b100000; functs[1] = 6'b100010; functs[2] = 6'b100100;
    functs[3] = 6'b100101; functs[4] = 6'b101010;

    reset = 1'b1;
    op = 6'b0;
    funct = 6'b0;
    zero = 1'b0;
    holdAndReleaseReset();

    applyStimulus(LW, 6'b0, 2, -1);
    applyStimulus(RTY, 6'b101010, 2, -1);
    applyStimulus(BEQ, 6'b0, 1, -1);
    applyStimulus(BEQ, 6'b0, 0, -1);
    applyStimulus(6'b111111, 6'b0, 1, -1);
    applyStimulus(JMP, 6'b0, 1, -1);
    applyStimulus(SW, 6'b0, 2, -1);
    applyStimulus(ADDI, 6'b0, 2, -1);
    applyStimulus(RTY, 6'b111111, 2, -1);
    applyStimulus(LW, 6'b0, 2, 3);
    holdAndReleaseReset();

    for (int n = 0; n < 80; n++) begin
      sel = int'($urandom_range(0, 6));
      case (sel)
        0: ro = LW;
        1: ro = SW;
        2: ro = RTY;
        3: ro = BEQ;
        4: ro = ADDI;
        5: ro = JMP;
        default: begin
          ro = 6'($urandom_range(0, 63));
          while (isSupported(ro)) ro = 6'($urandom_range(0, 63));
        end
      endcase
      if ($urandom_range(0, 1) == 1) rf = functs[$urandom_range(0, 4)];
      else                           rf = 6'($urandom_range(0, 63));
      abortAt = ($urandom_range(0, 9) == 0) ?
                int'($urandom_range(0, instrLatency(ro) - 1)) : -1;
      applyStimulus(ro, rf, 2, abortAt);
      if (abortAt >= 0) holdAndReleaseReset();
    end

    applyStimulus(ADDI, 6'b0, 2, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  6  instruction opcode, from the instruction register.
REQ-005 funct  input  6  R-type function field.
REQ-006 zero  input  1  ALU zero flag, valid in the same cycle as alucontrol.
REQ-007 alucontrol  output  3  ALU operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-008 alusrca  output  1  0 = PC, 1 = register A.
REQ-009 alusrcb  output  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
REQ-010 pcsrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-011 pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite  output  1 each  datapath enables and selects.

Function
REQ-012 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
REQ-013 Every output SHALL default to 0 in every state unless this section sets it.
REQ-014 FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, aluop=ADD, pcsrc=00, pcwrite=1; next state DECODE.
REQ-015 DECODE: alusrca=0, alusrcb=11, aluop=ADD.
REQ-016 Next state from DECODE by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 -> RTYPEEX
  - 000100 -> BEQEX
  - 001000 -> ADDIEX
  - 000010 -> JEX
  - any other op -> FETCH (no architectural side effects)
REQ-017 MEMADR: alusrca=1, alusrcb=10, ADD; next MEMRD for lw, MEMWR for sw.
REQ-018 MEMRD: iord=1; next MEMWB.
REQ-019 MEMWB: regdst=0, memtoreg=1, regwrite=1; next FETCH.
REQ-020 MEMWR: iord=1, memwrite=1; next FETCH.
REQ-021 RTYPEEX: alusrca=1, alusrcb=00, aluop=FUNCT; next RTYPEWB.
REQ-022 RTYPEWB: regdst=1, memtoreg=0, regwrite=1; next FETCH.
REQ-023 BEQEX: alusrca=1, alusrcb=00, aluop=SUB, pcsrc=01, branch=1; next FETCH.
REQ-024 ADDIEX: alusrca=1, alusrcb=10, ADD; next ADDIWB.
REQ-025 ADDIWB: regdst=0, memtoreg=0, regwrite=1; next FETCH.
REQ-026 JEX: pcsrc=10, pcwrite=1; next FETCH.
REQ-027 pcen SHALL be the combinational value pcwrite OR (branch AND zero), so zero is sampled in BEQEX only.
REQ-028 aluop=FUNCT SHALL decode funct as follows; any other funct SHALL give 010:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
REQ-029 Instruction latency SHALL be, in cycles from FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unsupported 2.
REQ-030 op and funct SHALL be sampled only by next-state and output logic; the block SHALL have no other storage besides the state register.

Reset
REQ-031 reset SHALL force state=FETCH immediately, without waiting for a clock edge, including mid-instruction.
REQ-032 While reset is high, the outputs SHALL be the FETCH outputs, and pcen, irwrite, memwrite and regwrite SHALL additionally be forced to 0.
REQ-033 After reset deasserts, the first rising edge SHALL perform the FETCH state's actions.

Structure
REQ-034 The state enum, opcode constants, funct constants, alucontrol encodings and the aluop type SHALL live in a shared package, mips_pkg.
REQ-035 The funct-to-alucontrol mapping SHALL be a combinational sub-module named aludec, instantiated once.

Verification
REQ-036 Reset asserted during MEMRD -> state FETCH within the same cycle; regwrite=0 and memwrite=0 until reset deasserts.
REQ-037 op=100011 -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in MEMWB.
REQ-038 op=000000, funct=101010 -> alucontrol=111 in RTYPEEX; regwrite=1 and regdst=1 in the next cycle.
REQ-039 op=000100 with zero=1 -> pcen=1 and pcsrc=01 in BEQEX; the same op with zero=0 -> pcen=0.
REQ-040 op=111111 -> DECODE then FETCH; memwrite, regwrite and pcen stay 0 in DECODE.
REQ-041 op=000010 -> pcen=1 and pcsrc=10 in JEX; total of 3 cycles.
